// File: rtl/gpio_debounce.sv
// Switch input conditioner: two-flop synchroniser, shared prescaler tick and a
// per-bit stability counter, producing clean levels plus rise/fall/changed pulses.
module gpio_debounce #(
  parameter int unsigned        NumBits     = 16,
  parameter int unsigned        TickCycles  = 30000,
  parameter int unsigned        StableTicks = 5,
  parameter logic [NumBits-1:0] ResetValue  = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumBits-1:0] raw_i,
  input  logic               bypass_i,
  output logic [NumBits-1:0] debounced_o,
  output logic [NumBits-1:0] rise_o,
  output logic [NumBits-1:0] fall_o,
  output logic               changed_o
);

  localparam int unsigned PresW = (TickCycles > 1) ? $clog2(TickCycles) : 1;
  localparam int unsigned CntW  = $clog2(StableTicks + 1);

  localparam logic [PresW-1:0] PresLast = PresW'(TickCycles - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(StableTicks - 1);

  logic [NumBits-1:0] sync1_q, sync2_q;
  logic [PresW-1:0]   pres_q;
  logic               tick;
  logic [CntW-1:0]    cnt_q [NumBits];
  logic [CntW-1:0]    cnt_d [NumBits];
  logic [NumBits-1:0] deb_d, rise_d, fall_d;

  // Synchroniser flops reset to the debounced reset level so no edge is seen
  // as the first real samples arrive.
  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetValue;
      sync2_q <= ResetValue;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Free-running prescaler; never paused by bypass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pres_q <= '0;
    end else if (pres_q == PresLast) begin
      pres_q <= '0;
    end else begin
      pres_q <= pres_q + 1'b1;
    end
  end

  assign tick = (pres_q == PresLast);

  // NOTE: every output of this block gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    deb_d = debounced_o;
    for (int i = 0; i < NumBits; i++) begin
      cnt_d[i] = '0;
      if (bypass_i) begin
        deb_d[i] = sync2_q[i];
      end else if (sync2_q[i] != debounced_o[i]) begin
        cnt_d[i] = cnt_q[i];
        if (tick) begin
          if (cnt_q[i] == CntLast) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
      end
    end
    rise_d = deb_d & ~debounced_o;
    fall_d = ~deb_d & debounced_o;
  end

  // NOTE: the counter array is small and must start from zero after every
  // reset, so it is reset like any other register rather than left as memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumBits; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumBits; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      debounced_o <= ResetValue;
      rise_o      <= '0;
      fall_o      <= '0;
      changed_o   <= 1'b0;
    end else begin
      debounced_o <= deb_d;
      rise_o      <= rise_d;
      fall_o      <= fall_d;
      changed_o   <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Self-checking bench for gpio_debounce: vector table, directed corner-case
// sequences and randomised stimulus against a tick-counting reference model.
module tb_gpio_debounce;

  localparam int NB = 4;
  localparam int TC = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bypass = 1'b0;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] deb, rise, fall;
  logic          chg;

  always #5 clk = ~clk;

  gpio_debounce #(
    .NumBits(NB), .TickCycles(TC), .StableTicks(ST), .ResetValue(4'b0000)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .raw_i(raw), .bypass_i(bypass),
    .debounced_o(deb), .rise_o(rise), .fall_o(fall), .changed_o(chg)
  );

  // Reference model: counts prescaler ticks seen during an unbroken mismatch
  // between the synchronised input and the current output.
  logic [NB-1:0] m_s1, m_s2, m_deb, m_rise, m_fall, m_deb_n;
  logic          m_chg, m_tick;
  int            m_phase;
  int            m_run   [NB];
  int            m_run_n [NB];

  always_comb begin
    m_tick  = (m_phase == TC - 1);
    m_deb_n = m_deb;
    for (int b = 0; b < NB; b++) begin
      m_run_n[b] = 0;
      if (bypass) begin
        m_deb_n[b] = m_s2[b];
      end else if (m_s2[b] != m_deb[b]) begin
        m_run_n[b] = m_run[b] + (m_tick ? 1 : 0);
        if (m_run_n[b] >= ST) begin
          m_deb_n[b] = m_s2[b];
          m_run_n[b] = 0;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_deb <= '0;
      m_rise <= '0; m_fall <= '0; m_chg <= 1'b0;
      m_phase <= 0;
      for (int b = 0; b < NB; b++) m_run[b] <= 0;
    end else begin
      m_s1    <= raw;
      m_s2    <= m_s1;
      m_deb   <= m_deb_n;
      m_rise  <= m_deb_n & ~m_deb;
      m_fall  <= ~m_deb_n & m_deb;
      m_chg   <= |(m_deb_n ^ m_deb);
      m_phase <= (m_phase + 1) % TC;
      m_run   <= m_run_n;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse statistics gathered by cycles().
  int            rise_n [NB];
  int            fall_n [NB];
  int            chg_n, rise_cycles, fall_cycles;
  logic [NB-1:0] rise_vec, fall_vec, rise_or, fall_or;
  bit            chk_hist = 1'b0;
  logic [NB-1:0] hist [$];

  task automatic clear_counts();
    for (int b = 0; b < NB; b++) begin
      rise_n[b] = 0;
      fall_n[b] = 0;
    end
    chg_n = 0; rise_cycles = 0; fall_cycles = 0;
    rise_vec = '0; fall_vec = '0; rise_or = '0; fall_or = '0;
  endtask

  task automatic cycles(input int n);
    logic [NB-1:0] old;
    for (int k = 0; k < n; k++) begin
      if (chk_hist) hist.push_back(raw);
      @(posedge clk);
      #1;
      check("model", {deb, rise, fall, chg}, {m_deb, m_rise, m_fall, m_chg});
      for (int b = 0; b < NB; b++) begin
        rise_n[b] += int'(rise[b]);
        fall_n[b] += int'(fall[b]);
      end
      if (rise != '0) begin rise_cycles++; rise_vec = rise; end
      if (fall != '0) begin fall_cycles++; fall_vec = fall; end
      chg_n   += int'(chg);
      rise_or |= rise;
      fall_or |= fall;
      if (chk_hist && hist.size() >= 3) begin
        old = hist[hist.size() - 3];
        check("bypass_latency", 32'(deb[3]), 32'(old[3]));
      end
    end
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic          byp;
    int            hold;
    logic [NB-1:0] exp_deb;
    logic [NB-1:0] exp_rise;
    logic [NB-1:0] exp_fall;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat;
    int rate;

    vecs[0] = '{4'b0101, 1'b1, 4,  4'b0101, 4'b0101, 4'b0000};
    vecs[1] = '{4'b1010, 1'b1, 4,  4'b1010, 4'b1010, 4'b0101};
    vecs[2] = '{4'b0000, 1'b1, 4,  4'b0000, 4'b0000, 4'b1010};
    vecs[3] = '{4'b1111, 1'b0, 16, 4'b1111, 4'b1111, 4'b0000};
    vecs[4] = '{4'b0110, 1'b0, 16, 4'b0110, 4'b0000, 4'b1001};
    vecs[5] = '{4'b0110, 1'b1, 4,  4'b0110, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0000, 1'b0, 16, 4'b0000, 4'b0000, 4'b0110};

    // Reset state, then quiet release.
    #12;
    check("reset_deb", 32'(deb), 32'h0);
    check("reset_pulses", {rise, fall, chg}, 32'h0);
    rst_n = 1'b1;
    clear_counts();
    cycles(50);
    check("quiet_deb", 32'(deb), 32'h0);
    check("quiet_pulses", 32'(chg_n + rise_cycles + fall_cycles), 32'h0);

    // Vector table.
    for (int v = 0; v < 7; v++) begin
      clear_counts();
      raw = vecs[v].raw;
      bypass = vecs[v].byp;
      cycles(vecs[v].hold);
      check($sformatf("vec%0d_deb", v), 32'(deb), 32'(vecs[v].exp_deb));
      check($sformatf("vec%0d_rise", v), 32'(rise_or), 32'(vecs[v].exp_rise));
      check($sformatf("vec%0d_fall", v), 32'(fall_or), 32'(vecs[v].exp_fall));
    end
    bypass = 1'b0;
    raw = '0;
    cycles(20);

    // Single rising edge: latency window and single pulse.
    clear_counts();
    lat = 0;
    raw[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      cycles(1);
      if (deb[0] && lat == 0) lat = k;
    end
    check("edge_latency_min", 32'(lat >= 11), 32'h1);
    check("edge_latency_max", 32'(lat <= 14), 32'h1);
    check("edge_rise_count", 32'(rise_n[0]), 32'h1);
    check("edge_fall_count", 32'(fall_n[0]), 32'h0);
    check("edge_changed_count", 32'(chg_n), 32'h1);

    // Glitches of 8 cycles at every prescaler phase are rejected.
    for (int off = 0; off < TC; off++) begin
      clear_counts();
      for (int k = 0; k < TC && m_phase != off; k++) cycles(1);
      raw[1] = 1'b1;
      cycles(8);
      raw[1] = 1'b0;
      cycles(20);
      check($sformatf("glitch%0d_deb", off), 32'(deb[1]), 32'h0);
      check($sformatf("glitch%0d_pulses", off), 32'(rise_n[1] + fall_n[1]), 32'h0);
    end

    // Bounce: the count restarts after the low gap.
    clear_counts();
    raw[2] = 1'b1;
    cycles(6);
    raw[2] = 1'b0;
    cycles(2);
    raw[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      cycles(1);
      if (rise[2] && lat == 0) lat = k;
    end
    check("bounce_rise_count", 32'(rise_n[2]), 32'h1);
    check("bounce_latency", 32'(lat >= 11 && lat <= 14), 32'h1);

    raw = '0;
    cycles(20);

    // Several bits together: one combined pulse cycle each way.
    clear_counts();
    raw = 4'b1011;
    cycles(20);
    check("multi_deb_rise", 32'(deb), 32'hb);
    check("multi_rise_vec", 32'(rise_vec), 32'hb);
    check("multi_rise_cycles", 32'(rise_cycles), 32'h1);
    check("multi_rise_changed", 32'(chg_n), 32'h1);
    clear_counts();
    raw = '0;
    cycles(20);
    check("multi_deb_fall", 32'(deb), 32'h0);
    check("multi_fall_vec", 32'(fall_vec), 32'hb);
    check("multi_fall_cycles", 32'(fall_cycles), 32'h1);
    check("multi_fall_changed", 32'(chg_n), 32'h1);

    // Bypass: 3-cycle follow, one pulse per edge, then async reset mid-pulse.
    bypass = 1'b1;
    cycles(4);
    clear_counts();
    hist.delete();
    chk_hist = 1'b1;
    for (int t = 0; t < 16; t++) begin
      raw[3] = ~raw[3];
      cycles(2);
    end
    cycles(2);
    check("bypass_rises", 32'(rise_n[3]), 32'h8);
    check("bypass_falls", 32'(fall_n[3]), 32'h8);
    raw[3] = 1'b1;
    cycles(3);
    chk_hist = 1'b0;
    check("pre_reset_rise", 32'(rise[3]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_deb", 32'(deb), 32'h0);
    check("async_reset_pulses", {rise, fall, chg}, 32'h0);
    raw = '0;
    bypass = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    cycles(20);
    check("post_reset_pulses", 32'(chg_n), 32'h0);

    // Randomised stimulus against the model with varying toggle rates.
    for (int seg = 0; seg < 8; seg++) begin
      rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 15 : 40);
      for (int k = 0; k < 500; k++) begin
        for (int b = 0; b < NB; b++)
          if ($urandom_range(rate) == 0) raw[b] = ~raw[b];
        if ($urandom_range(80) == 0) bypass = ~bypass;
        cycles(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
